// File: rtl/jpc_pc_unit.sv
// Fetch-stage program counter. Next PC comes from trap, redirect, return-address stack
// or sequential increment. All outputs are registered.
module jpc_pc_unit #(
   parameter int unsigned                ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = '0,
   parameter int unsigned                INCR         = 4,
   parameter int unsigned                RAS_DEPTH    = 4,
   parameter int unsigned                ALIGN_BITS   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en_I,
   input  logic                              redirect_I,
   input  logic [ADDR_WIDTH-1:0]             redirect_pc_I,
   input  logic                              trap_I,
   input  logic [ADDR_WIDTH-1:0]             trap_vec_I,
   input  logic                              call_I,
   input  logic                              ret_I,
   output logic [ADDR_WIDTH-1:0]             pc_O,
   output logic                              misaligned_O,
   output logic [$clog2(RAS_DEPTH+1)-1:0]    ras_count_O,
   output logic                              ras_empty_O,
   output logic                              ras_full_O
);

   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LowMask = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [CW-1:0] Depth   = CW'(RAS_DEPTH);
   localparam logic [PW-1:0] LastIdx = PW'(RAS_DEPTH - 1);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  mis_q, mis_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         tp_q, tp_d;
   logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

   logic                  ras_we;
   logic [PW-1:0]         ras_widx;
   logic [ADDR_WIDTH-1:0] seq_pc;
   logic [PW-1:0]         tp_inc, tp_dec;
   logic                  ret_hit;

   assign seq_pc  = pc_q + ADDR_WIDTH'(INCR);
   assign tp_inc  = (tp_q == LastIdx) ? '0 : tp_q + PW'(1);
   assign tp_dec  = (tp_q == '0) ? LastIdx : tp_q - PW'(1);
   assign ret_hit = ret_I && (cnt_q != '0);

   always_comb begin
      pc_d     = pc_q;
      mis_d    = 1'b0;
      cnt_d    = cnt_q;
      tp_d     = tp_q;
      ras_we   = 1'b0;
      ras_widx = tp_q;
      if (trap_I) begin
         pc_d  = trap_vec_I & ~LowMask;
         mis_d = |(trap_vec_I & LowMask);
         cnt_d = '0;
      end else if (redirect_I) begin
         pc_d  = redirect_pc_I & ~LowMask;
         mis_d = |(redirect_pc_I & LowMask);
      end else if (en_I) begin
         pc_d = ret_hit ? ras_q[tp_q] : seq_pc;
         if (call_I && ret_hit) begin
            // Pop and push in one cycle: overwrite the top in place.
            ras_we = 1'b1;
         end else if (call_I) begin
            ras_we   = 1'b1;
            ras_widx = tp_inc;
            tp_d     = tp_inc;
            if (cnt_q != Depth) cnt_d = cnt_q + CW'(1);
         end else if (ret_hit) begin
            tp_d  = tp_dec;
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
         mis_q <= 1'b0;
         cnt_q <= '0;
         tp_q  <= '0;
      end else begin
         pc_q  <= pc_d;
         mis_q <= mis_d;
         cnt_q <= cnt_d;
         tp_q  <= tp_d;
      end
   end

   // Stack entries are never cleared; only the count marks them valid.
   always_ff @(posedge clk) begin
      if (!rst && ras_we) ras_q[ras_widx] <= seq_pc;
   end

   assign pc_O         = pc_q;
   assign misaligned_O = mis_q;
   assign ras_count_O  = cnt_q;
   assign ras_empty_O  = (cnt_q == '0);
   assign ras_full_O   = (cnt_q == Depth);

endmodule

// File: tb/tb_jpc_pc_unit.sv
// Scoreboard bench for jpc_pc_unit: a queue-based RAS model predicts each cycle's outputs,
// a monitor compares them against the DUT after every rising edge.
module tb_jpc_pc_unit;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, en, redir, trap, call, ret;
   logic [31:0] rpc, tvec;
   logic [31:0] pc, pc_rv;
   logic        mis, mis_rv, empty, full, empty_rv, full_rv;
   logic [2:0]  cnt, cnt_rv;

   always #5 clk = ~clk;

   jpc_pc_unit #(.RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en_I(en), .redirect_I(redir), .redirect_pc_I(rpc),
      .trap_I(trap), .trap_vec_I(tvec), .call_I(call), .ret_I(ret), .pc_O(pc),
      .misaligned_O(mis), .ras_count_O(cnt), .ras_empty_O(empty), .ras_full_O(full)
   );

   jpc_pc_unit #(.RAS_DEPTH(DEPTH), .RESET_VECTOR(32'h80)) dut_rv (
      .clk(clk), .rst(rst), .en_I(en), .redirect_I(redir), .redirect_pc_I(rpc),
      .trap_I(trap), .trap_vec_I(tvec), .call_I(call), .ret_I(ret), .pc_O(pc_rv),
      .misaligned_O(mis_rv), .ras_count_O(cnt_rv), .ras_empty_O(empty_rv),
      .ras_full_O(full_rv)
   );

   typedef struct {
      logic [31:0] pc;
      logic        mis;
      int          cnt;
      bit          rv_ok;
      logic [31:0] rv_pc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_ras[$];
   bit          m_rv_ok;
   int          checks = 0;
   int          errors = 0;
   bit          done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Apply one cycle of inputs and predict the state after the next edge.
   task automatic step(input bit r, input bit e, input bit rd, input logic [31:0] rp,
                       input bit t, input logic [31:0] tv, input bit c, input bit rt);
      exp_t x;
      logic [31:0] nxt;
      @(negedge clk);
      rst = r; en = e; redir = rd; rpc = rp; trap = t; tvec = tv; call = c; ret = rt;
      if (r) begin
         m_pc = 32'h0; m_mis = 1'b0; m_ras.delete(); m_rv_ok = 1'b1;
      end else if (t) begin
         m_pc = tv & ~32'h3; m_mis = (tv[1:0] != 2'b0); m_ras.delete(); m_rv_ok = 1'b0;
      end else if (rd) begin
         m_pc = rp & ~32'h3; m_mis = (rp[1:0] != 2'b0); m_rv_ok = 1'b0;
      end else begin
         m_mis = 1'b0;
         if (e) begin
            nxt = m_pc + 32'd4;
            if (rt && m_ras.size() > 0) nxt = m_ras.pop_back();
            if (c) begin
               m_ras.push_back(m_pc + 32'd4);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = nxt;
         end
      end
      x.pc = m_pc; x.mis = m_mis; x.cnt = m_ras.size();
      x.rv_ok = m_rv_ok; x.rv_pc = m_pc + 32'h80;
      sb.push_back(x);
   endtask

   task automatic go(input bit c, input bit rt);
      step(0, 1, 0, 0, 0, 0, c, rt);
   endtask

   task automatic jump(input logic [31:0] a);
      step(0, 0, 1, a, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check("pc", pc, x.pc);
            check("misaligned", {31'b0, mis}, {31'b0, x.mis});
            check("ras_count", {29'b0, cnt}, x.cnt);
            check("ras_empty", {31'b0, empty}, {31'b0, (x.cnt == 0)});
            check("ras_full", {31'b0, full}, {31'b0, (x.cnt == DEPTH)});
            if (x.rv_ok) check("pc_reset_vector_0x80", pc_rv, x.rv_pc);
         end
      end
   end

   initial begin : driver
      int n;
      rst = 1; en = 0; redir = 0; trap = 0; call = 0; ret = 0; rpc = 0; tvec = 0;
      m_pc = 0; m_mis = 0; m_rv_ok = 0;
      // Reset then increment
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) go(0, 0);
      // Redirect while stalled, hold, trap beats redirect
      step(0, 0, 1, 32'h100, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 1, 32'h300, 1, 32'h200, 0, 0);
      // Call then return across a redirect
      jump(32'h10);
      go(1, 0);
      jump(32'h400);
      go(0, 1);
      // Overflow and underflow
      step(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (5) go(1, 0);
      repeat (5) go(0, 1);
      // Call+ret together, empty and non-empty
      go(1, 1);
      go(1, 1);
      go(0, 1);
      // Misaligned redirect and wrap
      jump(32'h103);
      go(0, 0);
      step(0, 0, 0, 0, 1, 32'h207, 0, 0);
      jump(32'hFFFF_FFFC);
      go(0, 0);
      // Reset mid-operation with call asserted
      repeat (3) go(1, 0);
      step(1, 1, 0, 0, 0, 0, 1, 0);
      // Random phase
      for (int i = 0; i < 3000; i++) begin
         n = $urandom_range(0, 99);
         step(n == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
              ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                           : $urandom,
              $urandom_range(0, 31) == 0, $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
